// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register bank completer.
// Holds the FSM state enum, default bus widths and wait-state limits.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int APB_ADDR_WIDTH = 8;
    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_MAX_WAIT   = 15;
    localparam int APB_CNT_W      = 4;

    // Number of low address bits that select a byte within a word.
    function automatic int apb_align(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/apb_regbank_slave_if.sv
// APB4/APB5 bus bundle between a requester and the register bank.
// Ports: PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB/PWAKEUP in, PRDATA/PREADY/PSLVERR out.
interface apb_regbank_slave_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0]   PADDR;
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic                    PWAKEUP;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PWAKEUP,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PWAKEUP,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_wait_ctrl.sv
// APB transfer sequencer: FSM, wait-state counter, ready and protocol checks.
// Ports: PCLK/PRESET, bus request inputs; ready (ungated), prot_err (registered pulse).
module apb_wait_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    ready,
    output logic                    prot_err
);

    // SETUP means the setup phase has been seen and the access phase
    // is due in the current cycle; ACCESS means wait states are running.
    apb_state_e state;
    apb_state_e state_nxt;

    logic [APB_CNT_W-1:0] wait_cnt;
    logic [APB_CNT_W-1:0] cnt_nxt;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] strb_q;

    logic acc;
    logic stable;
    logic viol;

    always_comb begin
        acc    = psel && penable && (state != IDLE);
        stable = (paddr == addr_q) && (pwrite == write_q)
              && (pwdata == wdata_q) && (pstrb == strb_q);

        viol = (penable && !psel)
            || (penable && (state == IDLE))
            || (acc && !stable)
            || ((state == ACCESS) && !psel);

        // A violating cycle never completes, so nothing can commit.
        ready = acc && (wait_cnt == '0) && !viol;

        state_nxt = IDLE;
        cnt_nxt   = '0;
        if (viol) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (acc) begin
            if (!ready) begin
                state_nxt = ACCESS;
                cnt_nxt   = wait_cnt - APB_CNT_W'(1);
            end
        end else if (psel && !penable) begin
            state_nxt = SETUP;
            cnt_nxt   = APB_CNT_W'(WAIT_STATES);
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            wait_cnt <= '0;
            prot_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            prot_err <= viol;
        end
    end

    // Previous-cycle request, used for the stability check.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
        end
    end

endmodule

// File: rtl/apb_regbank_slave.sv
// APB register bank: NUM_REGS byte-strobed registers behind one APB port.
// Ports: PCLK, PRESET, bus (slave), reg_q contents, wr_pulse per reg, prot_err.
module apb_regbank_slave
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    apb_regbank_slave_if.slave             bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic                           prot_err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int ALIGN = apb_align(DATA_WIDTH);

    localparam logic [ADDR_WIDTH-1:0] LANE_MASK =
        ADDR_WIDTH'((1 << ALIGN) - 1);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [ADDR_WIDTH-1:0] idx;
    logic                  err;
    logic                  ready;
    logic                  commit;
    logic                  rd_ok;
    logic [NUM_REGS-1:0]   hit;
    logic [DATA_WIDTH-1:0] rd_mux;

    function automatic logic [DATA_WIDTH-1:0] strb_merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [NB-1:0]         strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < NB; b++) begin
            if (strb[b]) begin
                r[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return r;
    endfunction

    apb_wait_ctrl #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .WAIT_STATES (WAIT_STATES)
    ) u_ctrl (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .psel     (bus.PSEL),
        .penable  (bus.PENABLE),
        .pwrite   (bus.PWRITE),
        .paddr    (bus.PADDR),
        .pwdata   (bus.PWDATA),
        .pstrb    (bus.PSTRB),
        .ready    (ready),
        .prot_err (prot_err)
    );

    assign idx = bus.PADDR >> ALIGN;

    // Extra bit keeps the bound check correct when NUM_REGS fills PADDR.
    assign err = ({1'b0, idx} >= (ADDR_WIDTH+1)'(NUM_REGS))
              || ((bus.PADDR & LANE_MASK) != '0)
              || !bus.PWAKEUP;

    always_comb begin
        hit    = '0;
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == ADDR_WIDTH'(i)) begin
                hit[i] = 1'b1;
                rd_mux = regs[i];
            end
        end
    end

    assign commit = ready && bus.PWRITE && !err && !PRESET;
    assign rd_ok  = ready && !bus.PWRITE && !err && !PRESET;

    assign wr_pulse    = commit ? hit : '0;
    assign bus.PREADY  = ready && !PRESET;
    assign bus.PSLVERR = ready && err && !PRESET;
    assign bus.PRDATA  = rd_ok ? rd_mux : '0;

    always_ff @(posedge PCLK) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (PRESET) begin
                regs[i] <= RESET_VAL;
            end else if (wr_pulse[i]) begin
                regs[i] <= strb_merge(regs[i], bus.PWDATA, bus.PSTRB);
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Bench for apb_regbank_slave: three instances (0, 2, 3 wait states)
// driven by directed and random transfers, checked against a bank model.
module tb_apb_regbank_slave;

    localparam int NI = 3;
    localparam int NR = 16;

    function automatic int ws(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic logic [31:0] rv(input int k);
        return (k == 2) ? 32'hC0DE_0001 : 32'h0;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [NI];
    logic [7:0]  d_addr  [NI];
    logic        d_sel   [NI];
    logic        d_en    [NI];
    logic        d_wr    [NI];
    logic        d_wake  [NI];
    logic [31:0] d_wdata [NI];
    logic [3:0]  d_strb  [NI];

    logic [31:0]     o_rdata  [NI];
    logic            o_ready  [NI];
    logic            o_slverr [NI];
    logic            o_prot   [NI];
    logic [NR*32-1:0] o_regq  [NI];
    logic [NR-1:0]   o_wr     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        apb_regbank_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

        assign bus.PADDR   = d_addr[g];
        assign bus.PSEL    = d_sel[g];
        assign bus.PENABLE = d_en[g];
        assign bus.PWRITE  = d_wr[g];
        assign bus.PWDATA  = d_wdata[g];
        assign bus.PSTRB   = d_strb[g];
        assign bus.PWAKEUP = d_wake[g];
        assign o_rdata[g]  = bus.PRDATA;
        assign o_ready[g]  = bus.PREADY;
        assign o_slverr[g] = bus.PSLVERR;

        apb_regbank_slave #(
            .ADDR_WIDTH  (8),
            .DATA_WIDTH  (32),
            .NUM_REGS    (NR),
            .WAIT_STATES (ws(g)),
            .RESET_VAL   (rv(g))
        ) dut (
            .PCLK     (clk),
            .PRESET   (rst[g]),
            .bus      (bus),
            .reg_q    (o_regq[g]),
            .wr_pulse (o_wr[g]),
            .prot_err (o_prot[g])
        );
    end

    // Reference model: register contents and per-cycle expectations.
    logic [31:0]   mem      [NI][NR];
    logic          e_ready  [NI];
    logic          e_slverr [NI];
    logic [31:0]   e_rdata  [NI];
    logic [NR-1:0] e_wr     [NI];
    bit            viol_now [NI];
    bit            viol_last[NI];
    bit            pend_w   [NI];
    int            pend_i   [NI];
    logic [31:0]   pend_v   [NI];
    bit            pend_rst [NI];
    bit            chk_on;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name,
                       input logic [NR*32-1:0] act,
                       input logic [NR*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [NR*32-1:0] eq;
        if (chk_on) begin
            for (int k = 0; k < NI; k++) begin
                for (int i = 0; i < NR; i++) eq[i*32 +: 32] = mem[k][i];
                chk($sformatf("pready%0d", k), o_ready[k], e_ready[k]);
                chk($sformatf("pslverr%0d", k), o_slverr[k], e_slverr[k]);
                chk($sformatf("prdata%0d", k), o_rdata[k], e_rdata[k]);
                chk($sformatf("wr_pulse%0d", k), o_wr[k], e_wr[k]);
                chk($sformatf("prot_err%0d", k), o_prot[k], viol_last[k]);
                chk($sformatf("reg_q%0d", k), o_regq[k], eq);
            end
        end
    end

    // Advance one cycle: retire the previous cycle's model effects and
    // leave every bus idle unless the caller drives it.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            viol_last[k] = viol_now[k];
            viol_now[k]  = 1'b0;
            if (pend_rst[k]) begin
                for (int i = 0; i < NR; i++) mem[k][i] = rv(k);
            end else if (pend_w[k]) begin
                mem[k][pend_i[k]] = pend_v[k];
            end
            pend_rst[k] = 1'b0;
            pend_w[k]   = 1'b0;
            e_ready[k]  = 1'b0;
            e_slverr[k] = 1'b0;
            e_rdata[k]  = '0;
            e_wr[k]     = '0;
            d_sel[k]    = 1'b0;
            d_en[k]     = 1'b0;
        end
    endtask

    task automatic drive(input int k, input bit sel, input bit en,
                         input bit wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input bit wake);
        d_sel[k]   = sel;
        d_en[k]    = en;
        d_wr[k]    = wr;
        d_addr[k]  = a;
        d_wdata[k] = d;
        d_strb[k]  = s;
        d_wake[k]  = wake;
    endtask

    task automatic xfer(input int k, input bit wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input bit wake, output logic [31:0] rd,
                        output logic se, output int lows);
        int ai;
        int idx;
        bit err;
        logic [31:0] nv;
        ai   = int'(a);
        idx  = ai / 4;
        err  = (ai % 4 != 0) || (idx >= NR) || !wake;
        lows = 0;
        rd   = '0;
        se   = 1'b0;
        step();
        drive(k, 1, 0, wr, a, d, s, wake);
        for (int j = 0; j <= ws(k); j++) begin
            step();
            drive(k, 1, 1, wr, a, d, s, wake);
            if (j == ws(k)) begin
                e_ready[k]  = 1'b1;
                e_slverr[k] = err;
                if (!err && wr) begin
                    nv = mem[k][idx];
                    for (int b = 0; b < 4; b++)
                        if (s[b]) nv[b*8 +: 8] = d[b*8 +: 8];
                    e_wr[k]   = NR'(1) << idx;
                    pend_w[k] = 1'b1;
                    pend_i[k] = idx;
                    pend_v[k] = nv;
                end else if (!err) begin
                    e_rdata[k] = mem[k][idx];
                end
            end
            @(negedge clk);
            if (!o_ready[k]) lows++;
            rd = o_rdata[k];
            se = o_slverr[k];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    logic [31:0] rd;
    logic        se;
    int          lows;

    initial begin
        chk_on = 1'b0;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1;
            drive(k, 0, 0, 0, 8'h0, 32'h0, 4'h0, 1);
            for (int i = 0; i < NR; i++) mem[k][i] = rv(k);
            e_ready[k]   = 1'b0;
            e_slverr[k]  = 1'b0;
            e_rdata[k]   = '0;
            e_wr[k]      = '0;
            viol_now[k]  = 1'b0;
            viol_last[k] = 1'b0;
            pend_w[k]    = 1'b0;
            pend_i[k]    = 0;
            pend_v[k]    = '0;
            pend_rst[k]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        chk_on = 1'b1;

        // Zero wait states: write then read back-to-back.
        xfer(0, 1, 8'h04, 32'hA5A5_1234, 4'hF, 1, rd, se, lows);
        chk("w0_wr_lows", 32'(lows), 32'd0);
        xfer(0, 0, 8'h04, 32'h0, 4'hF, 1, rd, se, lows);
        chk("w0_rd_lows", 32'(lows), 32'd0);
        chk("w0_rd_data", rd, 32'hA5A5_1234);

        // Three wait states: reset value read.
        xfer(2, 0, 8'h00, 32'h0, 4'hF, 1, rd, se, lows);
        chk("w3_lows", 32'(lows), 32'd3);
        chk("w3_rstval", rd, 32'hC0DE_0001);

        // Byte strobes.
        xfer(0, 1, 8'h08, 32'hFFFF_FFFF, 4'b0101, 1, rd, se, lows);
        xfer(0, 0, 8'h08, 32'h0, 4'hF, 1, rd, se, lows);
        chk("strb_data", rd, 32'h00FF_00FF);

        // Error responses.
        xfer(0, 1, 8'h40, 32'h1111_1111, 4'hF, 1, rd, se, lows);
        chk("err_oob_slverr", se, 1'b1);
        xfer(0, 0, 8'h05, 32'h0, 4'hF, 1, rd, se, lows);
        chk("err_mis_slverr", se, 1'b1);
        chk("err_mis_data", rd, 32'h0);
        xfer(0, 1, 8'h04, 32'h2222_2222, 4'hF, 0, rd, se, lows);
        chk("err_wake_slverr", se, 1'b1);
        xfer(0, 0, 8'h04, 32'h0, 4'hF, 1, rd, se, lows);
        chk("err_keep_data", rd, 32'hA5A5_1234);

        // PENABLE without a setup phase.
        step();
        drive(0, 1, 1, 1, 8'h04, 32'h0, 4'hF, 1);
        viol_now[0] = 1'b1;
        step();
        @(negedge clk);
        chk("noset_prot", o_prot[0], 1'b1);
        xfer(0, 0, 8'h04, 32'h0, 4'hF, 1, rd, se, lows);
        chk("noset_keep", rd, 32'hA5A5_1234);

        // Address changes during a wait state.
        step();
        drive(1, 1, 0, 1, 8'h0C, 32'hDEAD_BEEF, 4'hF, 1);
        step();
        drive(1, 1, 1, 1, 8'h0C, 32'hDEAD_BEEF, 4'hF, 1);
        step();
        drive(1, 1, 1, 1, 8'h10, 32'hDEAD_BEEF, 4'hF, 1);
        viol_now[1] = 1'b1;
        step();
        @(negedge clk);
        chk("chg_prot", o_prot[1], 1'b1);
        xfer(1, 0, 8'h0C, 32'h0, 4'hF, 1, rd, se, lows);
        chk("chg_keep", rd, 32'h0);

        // Reset in the second wait cycle of a write.
        step();
        drive(2, 1, 0, 1, 8'h08, 32'h1234_5678, 4'hF, 1);
        step();
        drive(2, 1, 1, 1, 8'h08, 32'h1234_5678, 4'hF, 1);
        step();
        drive(2, 1, 1, 1, 8'h08, 32'h1234_5678, 4'hF, 1);
        rst[2]      = 1'b1;
        pend_rst[2] = 1'b1;
        @(negedge clk);
        chk("rst_pready", o_ready[2], 1'b0);
        step();
        rst[2] = 1'b0;
        xfer(2, 0, 8'h08, 32'h0, 4'hF, 1, rd, se, lows);
        chk("rst_keep", rd, 32'hC0DE_0001);
        chk("rst_lows", 32'(lows), 32'd3);
        chk("rst_slverr", se, 1'b0);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            int k;
            int r;
            bit wr;
            bit wake;
            logic [7:0] a;
            k    = int'($urandom_range(0, NI - 1));
            wr   = 1'($urandom_range(0, 1));
            wake = ($urandom_range(0, 15) != 0);
            r    = int'($urandom_range(0, 9));
            if (r < 7)       a = 8'($urandom_range(0, 15) * 4);
            else if (r == 7) a = 8'($urandom_range(16, 63) * 4);
            else if (r == 8) a = 8'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else             a = 8'($urandom_range(0, 255));
            xfer(k, wr, a, $urandom, 4'($urandom_range(0, 15)), wake,
                 rd, se, lows);
            if ($urandom_range(0, 3) == 0) step();
        end

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
